circle_plotter: RTL and testbench
=================================

# circle_plotter

Parametrised pixel-stream generator for the VGA framebuffer path. It draws one midpoint (Bresenham) circle of arbitrary centre, radius and colour, or performs a full-screen clear, per start command. It sits between the top-level sequencing FSM (for example the Olympic-rings sequencer) and the VGA adapter's pixel write port. It adds screen clipping, output back-pressure and a start/busy/done command handshake.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- R_W, 7, radius width (unsigned)

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- resetn  in  1  reset, synchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = draw circle, 1 = clear screen
- cx  in  X_W  circle centre x (unsigned)
- cy  in  Y_W  circle centre y (unsigned)
- radius  in  R_W  circle radius (unsigned)
- colour_in  in  3  pixel colour {R,G,B}
- plot_ready  in  1  sink accepts pixel this cycle
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel valid
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLR, INIT, EMIT, STEP, DONE.
- IDLE, start=1: latch mode, cx, cy, radius and colour_in.
  - mode=1: go to CLR.
  - mode=0: go to INIT.
  - start while busy is ignored.
- CLR: raster sweep with x fastest, x 0..SCREEN_W-1, y 0..SCREEN_H-1, plot=1, colour = latched colour.
  - After the pixel (SCREEN_W-1, SCREEN_H-1) is accepted, go to DONE.
- INIT: ox = radius, oy = 0, crit = 1 - radius, octant counter k = 0.
- EMIT: one cycle per k = 0..7. Candidate point by k:
  - k=0: (cx+ox, cy+oy)
  - k=1: (cx+oy, cy+ox)
  - k=2: (cx-ox, cy+oy)
  - k=3: (cx-oy, cy+ox)
  - k=4: (cx-ox, cy-oy)
  - k=5: (cx-oy, cy-ox)
  - k=6: (cx+ox, cy-oy)
  - k=7: (cx+oy, cy-ox)
- Clipping: a candidate with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H has plot=0 for that cycle and still consumes the cycle. After k=7, go to STEP.
- STEP: oy' = oy+1.
  - If crit<=0: crit += 2*oy'+1, ox unchanged.
  - Else: ox' = ox-1, crit += 2*(oy'-ox')+1.
  - If oy' > ox', go to DONE. Otherwise go to EMIT with k=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic widths:
  - ox, oy: signed, R_W+2 bits.
  - crit: signed, 2*R_W+3 bits.
  - Candidate sums: signed, max(X_W,Y_W)+2 bits, so there is no wrap. Coordinates are truncated to X_W/Y_W only after the clip test.
- radius=0 emits the centre pixel 8 times (duplicates permitted), then goes to DONE.
- Duplicate pixels on octant boundaries are permitted.

## Timing
- Reset (resetn=0 at a clock edge):
  - state = IDLE.
  - x=0, y=0, colour=0, plot=0, busy=0, done=0.
  - Internal counters are cleared.
  - Reset mid-operation aborts with no done pulse.
- Outputs are registered. x/y/colour/plot change only on a clock edge.
- Back-pressure: in EMIT or CLR, plot=1 with plot_ready=0 freezes state, k and all outputs until plot_ready=1. Clipped points (plot=0) never wait.
- Circle latency with plot_ready held 1, with start sampled at edge 0:
  - INIT at cycle 1.
  - Iteration i (i=0..N-1) covers cycles 2+9i .. 10+9i (8 EMIT cycles + 1 STEP).
  - done at cycle 2+9N.
  - busy falls the cycle after done.
- Clear latency with plot_ready held 1: done at cycle 1+SCREEN_W*SCREEN_H. That is 19201 for the defaults.
- start asserted in the same cycle as done is ignored. The next command is accepted one cycle after done.

## Test plan
- Reset: hold resetn=0 for 2 cycles mid-circle, then release. Required: all outputs 0, busy=0, no done pulse; the next start is accepted normally.
- Circle r=24 at (80,60), plot_ready=1:
  - First 8 pixels: (104,60), (80,84), (56,60), (80,84), (56,60), (80,36), (104,60), (80,36).
  - Every emitted point satisfies |(x-80)^2+(y-60)^2-576| <= 48.
  - done arrives 2+9N cycles after start, where N = iterations until oy>ox.
- Clipping, r=10 at (2,3): no plot with x or y out of range. Cycle count equals that of the same radius at (80,60).
- radius=0 at (5,5): exactly 8 plots, all at (5,5); done at cycle 11.
- Clear with colour 3'b111, plot_ready=1: 19200 plots in raster order, last pixel (159,119); done at cycle 19201.
- Back-pressure: random plot_ready at 50% during r=24. Required: identical pixel sequence to the plot_ready=1 run, no drops or duplicates across stalls, and start pulses while busy are ignored.

Source files
------------

// File: rtl/circle_plotter_if.sv
// Command and pixel-stream bundle between a sequencer (master) and circle_plotter (slave).
// The widths must match the X_W/Y_W/R_W parameters of the connected circle_plotter.
interface circle_plotter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int R_W = 7
);
  logic           start;
  logic           mode;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [R_W-1:0] radius;
  logic [2:0]     colour_in;
  logic           plot_ready;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output start, mode, cx, cy, radius, colour_in, plot_ready,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, cx, cy, radius, colour_in, plot_ready,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/circle_plotter.sv
// Midpoint circle / full-screen clear pixel generator with clipping, back-pressure
// and a start/busy/done command handshake. All outputs are registered.
module circle_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 7
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  circle_plotter_if.slave bus
);

  localparam int CW  = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int OW  = R_W + 2;
  localparam int RW2 = 2 * R_W + 3;

  typedef enum logic [2:0] {IDLE, CLR, INIT, EMIT, STEP, DONE} state_t;

  state_t                state;
  logic [X_W-1:0]        cx_l;
  logic [Y_W-1:0]        cy_l;
  logic [R_W-1:0]        r_l;
  logic [2:0]            col_l;
  logic signed [OW-1:0]  ox, oy;
  logic signed [RW2-1:0] crit;
  logic [2:0]            k;

  logic [X_W-1:0]        pix_x;
  logic [Y_W-1:0]        pix_y;
  logic [2:0]            pix_col;
  logic                  pix_plot;
  logic                  busy_q;
  logic                  done_q;

  assign bus.x      = pix_x;
  assign bus.y      = pix_y;
  assign bus.colour = pix_col;
  assign bus.plot   = pix_plot;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  // Next midpoint iteration, used by STEP.
  logic signed [OW-1:0]  oy_n, ox_n;
  logic signed [RW2-1:0] crit_n;
  logic                  crit_pos;

  always_comb begin
    crit_pos = !crit[RW2-1] && (crit != '0);
    oy_n     = oy + OW'(1);
    ox_n     = ox;
    crit_n   = crit + (RW2'(oy_n) <<< 1) + RW2'(1);
    if (crit_pos) begin
      ox_n   = ox - OW'(1);
      crit_n = crit + (RW2'(oy_n - ox_n) <<< 1) + RW2'(1);
    end
  end

  // The output registers always hold the pixel for the current k, so the
  // candidate is computed for the point that becomes current at the next edge.
  logic [2:0]            k_sel;
  logic signed [OW-1:0]  ox_sel, oy_sel;
  logic signed [CW-1:0]  cxe, cye, oxe, oye, sx, sy;
  logic                  in_range;

  always_comb begin
    k_sel  = k + 3'd1;
    ox_sel = ox;
    oy_sel = oy;
    case (state)
      INIT: begin
        k_sel  = 3'd0;
        ox_sel = OW'(r_l);
        oy_sel = '0;
      end
      STEP: begin
        k_sel  = 3'd0;
        ox_sel = ox_n;
        oy_sel = oy_n;
      end
      default: ;
    endcase

    cxe = CW'(cx_l);
    cye = CW'(cy_l);
    oxe = CW'(ox_sel);
    oye = CW'(oy_sel);
    sx  = cxe + oxe;
    sy  = cye + oye;
    case (k_sel)
      3'd0: begin sx = cxe + oxe; sy = cye + oye; end
      3'd1: begin sx = cxe + oye; sy = cye + oxe; end
      3'd2: begin sx = cxe - oxe; sy = cye + oye; end
      3'd3: begin sx = cxe - oye; sy = cye + oxe; end
      3'd4: begin sx = cxe - oxe; sy = cye - oye; end
      3'd5: begin sx = cxe - oye; sy = cye - oxe; end
      3'd6: begin sx = cxe + oxe; sy = cye - oye; end
      3'd7: begin sx = cxe + oye; sy = cye - oxe; end
      default: ;
    endcase
    in_range = !sx[CW-1] && !sy[CW-1] &&
               (sx < CW'(SCREEN_W)) && (sy < CW'(SCREEN_H));
  end

  logic stalled;
  assign stalled = pix_plot && !bus.plot_ready;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= IDLE;
      cx_l     <= '0;
      cy_l     <= '0;
      r_l      <= '0;
      col_l    <= '0;
      ox       <= '0;
      oy       <= '0;
      crit     <= '0;
      k        <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      pix_col  <= '0;
      pix_plot <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cx_l    <= bus.cx;
            cy_l    <= bus.cy;
            r_l     <= bus.radius;
            col_l   <= bus.colour_in;
            pix_col <= bus.colour_in;
            busy_q  <= 1'b1;
            if (bus.mode) begin
              pix_x    <= '0;
              pix_y    <= '0;
              pix_plot <= 1'b1;
              state    <= CLR;
            end else begin
              state <= INIT;
            end
          end
        end

        CLR: begin
          if (bus.plot_ready) begin
            if (pix_x == X_W'(SCREEN_W - 1)) begin
              pix_x <= '0;
              if (pix_y == Y_W'(SCREEN_H - 1)) begin
                pix_y    <= '0;
                pix_plot <= 1'b0;
                done_q   <= 1'b1;
                state    <= DONE;
              end else begin
                pix_y <= pix_y + 1'b1;
              end
            end else begin
              pix_x <= pix_x + 1'b1;
            end
          end
        end

        INIT: begin
          ox       <= OW'(r_l);
          oy       <= '0;
          crit     <= RW2'(1) - RW2'(r_l);
          k        <= '0;
          pix_x    <= sx[X_W-1:0];
          pix_y    <= sy[Y_W-1:0];
          pix_col  <= col_l;
          pix_plot <= in_range;
          state    <= EMIT;
        end

        EMIT: begin
          if (!stalled) begin
            if (k == 3'd7) begin
              pix_plot <= 1'b0;
              state    <= STEP;
            end else begin
              k        <= k + 3'd1;
              pix_x    <= sx[X_W-1:0];
              pix_y    <= sy[Y_W-1:0];
              pix_plot <= in_range;
            end
          end
        end

        STEP: begin
          ox   <= ox_n;
          oy   <= oy_n;
          crit <= crit_n;
          if (oy_n > ox_n) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            k        <= '0;
            pix_x    <= sx[X_W-1:0];
            pix_y    <= sy[Y_W-1:0];
            pix_plot <= in_range;
            state    <= EMIT;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_plotter.sv
// Scoreboard bench for circle_plotter: a plain-arithmetic reference model queues the
// expected pixel stream, and a negedge monitor pops and compares each accepted pixel.
module tb_circle_plotter;

  localparam int SW = 160;
  localparam int SH = 120;

  logic clk;
  logic resetn;

  circle_plotter_if #(.X_W(8), .Y_W(7), .R_W(7)) bus ();

  circle_plotter #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_W(8), .Y_W(7), .R_W(7)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int n_plots  = 0;
  int last_pix = 0;
  bit bp_en    = 0;
  bit ring_chk = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  function automatic int pack(input int px, input int py, input int col);
    return px * 1024 + py * 8 + col;
  endfunction

  // Reference: points on the eight octants in the listed order, off-screen ones dropped.
  task automatic model_circle(input int cx0, input int cy0, input int r, input int col,
                              output int iters);
    int xs[8] = '{1, 1, -1, -1, -1, -1, 1, 1};
    int ys[8] = '{1, 1, 1, 1, -1, -1, -1, -1};
    int ox, oy, crit, px, py;
    ox = r; oy = 0; crit = 1 - r; iters = 0;
    do begin
      for (int k = 0; k < 8; k++) begin
        if (k % 2 == 0) begin px = cx0 + xs[k] * ox; py = cy0 + ys[k] * oy; end
        else            begin px = cx0 + xs[k] * oy; py = cy0 + ys[k] * ox; end
        if (px >= 0 && px < SW && py >= 0 && py < SH) exp_q.push_back(pack(px, py, col));
      end
      iters++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin ox--; crit += 2 * (oy - ox) + 1; end
    end while (oy <= ox);
  endtask

  // Monitor: a pixel is transferred at the edge following a negedge where plot && plot_ready.
  always @(negedge clk) begin
    if (resetn && bus.plot && bus.plot_ready) begin
      int act;
      act = pack(int'(bus.x), int'(bus.y), int'(bus.colour));
      n_plots++;
      last_pix = act;
      if (exp_q.size() == 0) check("unexpected_pixel", act, -1);
      else                   check("pixel", act, exp_q.pop_front());
      if (ring_chk) begin
        int dx, dy, d;
        dx = int'(bus.x) - 80; dy = int'(bus.y) - 60;
        d  = dx * dx + dy * dy - 576;
        check("ring_error_within_48", int'(d <= 48 && d >= -48), 1);
      end
    end
  end

  initial begin
    bus.plot_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.plot_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic issue(input bit m, input int cx0, input int cy0, input int r, input int col);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = m;
    bus.cx = 8'(cx0); bus.cy = 7'(cy0); bus.radius = 7'(r); bus.colour_in = 3'(col);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_cmd(input bit m, input int cx0, input int cy0, input int r, input int col,
                         input bit bp, input int exp_done, output int meas);
    int n;
    bit got;
    n_plots = 0;
    bp_en   = bp;
    issue(m, cx0, cy0, r, col);
    n = 0; got = 0;
    while (!got && n < 25000) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1;
      else if (bp && bus.busy && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1; bus.mode = 1'($urandom);
        bus.cx = 8'($urandom); bus.cy = 7'($urandom);
        bus.radius = 7'($urandom); bus.colour_in = 3'($urandom);
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    bp_en = 0;
    meas  = n;
    check("done_seen", int'(got), 1);
    if (got && exp_done >= 0) check("done_cycle", n, exp_done);
    @(negedge clk);
    check("busy_done_low_after", int'({bus.busy, bus.done}), 0);
    check("pixels_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int it, meas, c_mid, c_edge, dn;
    bus.start = 1'b0; bus.mode = 1'b0; bus.cx = '0; bus.cy = '0;
    bus.radius = '0; bus.colour_in = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 0);
    @(posedge clk); #1 resetn = 1'b1;

    // Abort a circle mid-flight with a two-cycle reset.
    model_circle(80, 60, 24, 2, it);
    issue(1'b0, 80, 60, 24, 2);
    repeat (30) @(negedge clk);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("midop_reset_outputs",
          int'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 0);
    resetn = 1'b1;
    exp_q.delete();
    dn = 0;
    repeat (20) begin @(negedge clk); if (bus.done || bus.busy || bus.plot) dn++; end
    check("no_activity_after_reset", dn, 0);

    // Reference circle, free-flowing sink.
    ring_chk = 1;
    model_circle(80, 60, 24, 5, it);
    run_cmd(1'b0, 80, 60, 24, 5, 1'b0, 2 + 9 * it, meas);
    ring_chk = 0;

    // Same radius centred and near the corner: identical timing, clipped output.
    model_circle(80, 60, 10, 3, it);
    run_cmd(1'b0, 80, 60, 10, 3, 1'b0, 2 + 9 * it, c_mid);
    model_circle(2, 3, 10, 6, it);
    run_cmd(1'b0, 2, 3, 10, 6, 1'b0, 2 + 9 * it, c_edge);
    check("clip_cycle_count", c_edge, c_mid);

    // Degenerate radius.
    model_circle(5, 5, 0, 1, it);
    run_cmd(1'b0, 5, 5, 0, 1, 1'b0, 11, meas);
    check("r0_plot_count", n_plots, 8);

    // Full-screen clear.
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++) exp_q.push_back(pack(xx, yy, 7));
    run_cmd(1'b1, 0, 0, 0, 7, 1'b0, 1 + SW * SH, meas);
    check("clear_plot_count", n_plots, SW * SH);
    check("clear_last_pixel", last_pix, pack(SW - 1, SH - 1, 7));

    // Reference circle under random back-pressure with ignored start pulses.
    ring_chk = 1;
    model_circle(80, 60, 24, 5, it);
    run_cmd(1'b0, 80, 60, 24, 5, 1'b1, -1, meas);
    ring_chk = 0;

    // Random circles.
    for (int t = 0; t < 4; t++) begin
      int rcx, rcy, rr, rcol;
      bit rbp;
      rcx = $urandom_range(0, 159); rcy = $urandom_range(0, 119);
      rr = $urandom_range(0, 60); rcol = $urandom_range(0, 7); rbp = 1'($urandom);
      model_circle(rcx, rcy, rr, rcol, it);
      run_cmd(1'b0, rcx, rcy, rr, rcol, rbp, rbp ? -1 : 2 + 9 * it, meas);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
